// File: rtl/pyc_queue_pkg.sv
// Shared sizing helpers for pyCircuit queues and FIFOs: counter and pointer widths
// derived from an entry count that need not be a power of two.
package pyc_queue_pkg;

    // Width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width able to index depth entries; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pyc_queue_ptr.sv
// Modulo-DEPTH wrap counter used as a queue read or write pointer.
// clr has priority over inc; rst returns the pointer to entry 0.
module pyc_queue_ptr
    import pyc_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [ptr_w(DEPTH)-1:0]   ptr
);

    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;

    // Explicit wrap compare so non-power-of-two depths skip the unused codes.
    always_comb begin
        ptr_next = ptr_reg;
        if (clr) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = (ptr_reg == PW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/pyc_queue_flex.sv
// Ready/valid queue of arbitrary depth with optional FLOW bypass and PIPE pass-through.
// Define PYC_QUEUE_FLUSH_EN to make the flush port live; otherwise flush is ignored.
module pyc_queue_flex
    import pyc_queue_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 2,
    parameter int FLOW         = 0,
    parameter int PIPE         = 0,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    generate
        if (DEPTH < 1) begin : g_depth_chk
            $error("pyc_queue_flex: DEPTH must be at least 1");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_afull_chk
            $error("pyc_queue_flex: AFULL_THRESH must lie in 1..DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             flush_eff;
    logic             hold;
    logic             is_empty;
    logic             is_full;
    logic             enq;
    logic             deq;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;

`ifdef PYC_QUEUE_FLUSH_EN
    assign flush_eff = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_eff    = 1'b0;
`endif

    always_comb begin
        is_empty  = (count_reg == '0);
        is_full   = (count_reg == CW'(DEPTH));
        hold      = rst | flush_eff;
        in_ready  = !hold && (!is_full || (PIPE != 0 && out_ready));
        out_valid = !hold && (!is_empty || (FLOW != 0 && in_valid));
        out_data  = (FLOW != 0 && is_empty) ? in_data : mem[rd_ptr];
        enq       = in_valid && in_ready;
        deq       = out_valid && out_ready;
        // An empty FLOW queue hands the datum straight through without touching storage.
        bypass    = (FLOW != 0) && is_empty && enq && deq;
        wr_en     = enq && !bypass;
        rd_en     = deq && !bypass;
        count_next = count_reg;
        if (wr_en && !rd_en) begin
            count_next = count_reg + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (hold) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    pyc_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush_eff),
        .inc (wr_en),
        .ptr (wr_ptr)
    );

    pyc_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush_eff),
        .inc (rd_en),
        .ptr (rd_ptr)
    );

    assign count       = count_reg;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_reg >= CW'(AFULL_THRESH));

endmodule

// File: doc/pyc_queue_flex.md
# pyc_queue_flex

Parametrised ready/valid queue for pyCircuit-generated designs. It generalises the single-mode queue to arbitrary depth, including non-power-of-two depths. Two mode switches are selectable at elaboration: FLOW (empty bypass) and PIPE (ready pass-through when full). It also exports occupancy and almost-full status. It sits between any two ready/valid stages where the existing queue's fixed behaviour is insufficient.

## Interface
- WIDTH, 1, payload width in bits (≥1)
- DEPTH, 2, entries of storage (≥1; any integer, not restricted to powers of two)
- FLOW, 0, 1 = data passes combinationally from input to output when empty
- PIPE, 0, 1 = in_ready asserted when full if out_ready is high (dequeue frees a slot in the same cycle)
- AFULL_THRESH, DEPTH-1, almost_full asserts when count ≥ AFULL_THRESH; legal range 1..DEPTH
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all stored entries (see Configuration)
- in_valid  in  1  producer has data
- in_ready  out  1  queue accepts data this cycle
- in_data  in  WIDTH  payload
- out_valid  out  1  queue presents data
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  payload at head
- count  out  CW  stored entries, where CW = $clog2(DEPTH+1)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_THRESH

## Operation
- State:
  - mem[DEPTH] of WIDTH bits
  - rd_ptr and wr_ptr, each 0..DEPTH-1
  - count, 0..DEPTH
- Definitions: enq = in_valid & in_ready; deq = out_valid & out_ready.
- out_valid:
  - 1 if count ≠ 0.
  - Otherwise FLOW & in_valid.
- out_data:
  - mem[rd_ptr] when count ≠ 0.
  - Otherwise in_data (FLOW=1), or don't-care (FLOW=0).
- in_ready = (count ≠ DEPTH) | (PIPE & out_ready).
- Bypass: when count == 0, FLOW=1 and enq & deq, nothing is written and pointers and count are unchanged.
- Write (enq, not bypassed):
  - mem[wr_ptr] ← in_data.
  - wr_ptr increments, wrapping from DEPTH-1 to 0.
- Read (deq, not bypassed): rd_ptr increments with the same wrap.
- count_next = count + write - read.
  - Simultaneous write and read leaves count unchanged.
  - A full queue with PIPE=1 and enq & deq stays full.
  - An empty queue with FLOW=0 cannot read.
- No overflow or underflow is possible by construction. An enq while in_ready=0 is ignored.
- While rst or an effective flush is high, in_ready = 0 and out_valid = 0, overriding the equations above.

## Timing
- Reset, applied at the first posedge with rst=1:
  - count = 0, rd_ptr = 0, wr_ptr = 0.
  - empty = 1, full = 0, almost_full = 0.
  - mem contents are not reset.
- Latency:
  - FLOW=0: an entry enqueued at edge N is visible on out_valid/out_data after edge N (next cycle).
  - FLOW=1 and empty: 0 cycles.
- in_ready depends combinationally on out_ready only when PIPE=1. out_valid depends combinationally on in_valid only when FLOW=1.
- Status outputs (count, empty, full, almost_full) are registered-state decodes and glitch-free relative to the handshake inputs.
- rst mid-transfer: the entry offered in that cycle is not accepted, and all stored entries are discarded.
- flush (when enabled) has the same effect as rst and overrides enq/deq in that cycle. Priority: rst > flush > normal operation.

## Configuration
- Macro: PYC_QUEUE_FLUSH_EN.
- Defined: the flush port is live and behaves exactly as described in Timing.
- Undefined:
  - The flush port exists but is ignored. No gating of in_ready or out_valid, and no pointer clear.
  - Synthesis removes the logic.

## Structure
- Shared package pyc_queue_pkg:
  - function cnt_w(depth) returning $clog2(depth+1)
  - function ptr_w(depth) returning max(1, $clog2(depth))
  - Both are reused by pyc_queue and future FIFOs.
- One sub-module, pyc_queue_ptr: a modulo-DEPTH wrap counter with inc and clr inputs. It is instantiated twice, for rd_ptr and wr_ptr.
- Elaboration-time checks in a generate block:
  - DEPTH ≥ 1
  - AFULL_THRESH in 1..DEPTH

## Test plan
- Fill/drain, DEPTH=3, WIDTH=8, FLOW=0, PIPE=0:
  - Enqueue 0x11, 0x22, 0x33 with out_ready=0: count reaches 3, full=1, in_ready=0.
  - Then out_ready=1: outputs 0x11, 0x22, 0x33 in order; empty=1 after 3 cycles.
- Wrap, DEPTH=3: stream 10 values 0..9 with continuous enq/deq and 1 entry resident. Output order is 0..9, count stays 1, and pointers wrap past index 2 without loss.
- FLOW=1, empty, out_ready=1, in_valid=1, in_data=0xA5: out_valid=1 and out_data=0xA5 in the same cycle; count stays 0.
- PIPE=1, full (DEPTH=2), out_ready=1, in_valid=1: in_ready=1, head dequeues, new entry written, count stays 2. With PIPE=0 in the same state, in_ready=0.
- almost_full, DEPTH=4, AFULL_THRESH=3: count 2 gives almost_full=0; count 3 gives 1; count 4 gives 1.
- Flush with PYC_QUEUE_FLUSH_EN defined: with count=2, pulse flush while in_valid=1. The next cycle shows count=0 and empty=1, the offered datum is dropped, and in_ready=0 and out_valid=0 during the flush cycle. With the macro undefined, the same stimulus leaves count=3.
